// File: rtl/axis2grid.sv
// ---------------------------------------------------------------------------
// axis2grid: AXI-Stream pixel frame -> WIDTH x HEIGHT alive-cell bitmap.
// Optional AXIS2GRID_COLOR_MASK_EN adds alive_mask. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis2grid #(
  parameter int DWIDTH = 32,
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DWIDTH-1:0]         alive_color,
`ifdef AXIS2GRID_COLOR_MASK_EN
  input  logic [DWIDTH-1:0]         alive_mask,
`endif
  input  logic [DWIDTH-1:0]         S_AXIS_TDATA,
  input  logic                      S_AXIS_TVALID,
  input  logic                      S_AXIS_TLAST,
  output logic                      S_AXIS_TREADY,
  output logic [WIDTH*HEIGHT-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      frame_err,
  output logic [15:0]               frame_count,
  output logic [15:0]               err_count
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DRAIN   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t          state, next_state;
  logic [IW-1:0]   idx;
  logic [N-1:0]    shadow;
  logic [N-1:0]    frame_bits;
  logic            alive;
  logic            accept;
  logic            complete;
  logic            err;

`ifdef AXIS2GRID_COLOR_MASK_EN
  assign alive = ((S_AXIS_TDATA & alive_mask) == (alive_color & alive_mask));
`else
  assign alive = (S_AXIS_TDATA == alive_color);
`endif

  assign S_AXIS_TREADY = (state != PRESENT);
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign out_valid     = (state == PRESENT);

  // Final cell is merged combinationally so the frame lands in one cycle.
  always_comb begin
    frame_bits      = shadow;
    frame_bits[idx] = alive;
  end

  always_comb begin
    next_state = state;
    complete   = 1'b0;
    err        = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (S_AXIS_TLAST && (idx == LAST_IDX)) begin
            complete   = 1'b1;
            next_state = PRESENT;
          end else if (S_AXIS_TLAST) begin
            err = 1'b1;
          end else if (idx == LAST_IDX) begin
            err        = 1'b1;
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept && S_AXIS_TLAST) next_state = FILL;
      end
      PRESENT: begin
        if (out_ready) next_state = FILL;
      end
      default: next_state = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= FILL;
      idx         <= '0;
      shadow      <= '0;
      out_data    <= '0;
      frame_err   <= 1'b0;
      frame_count <= 16'd0;
      err_count   <= 16'd0;
    end else begin
      state     <= next_state;
      frame_err <= err;
      if ((state == FILL) && accept) begin
        shadow[idx] <= alive;
        idx         <= (complete || err) ? '0 : idx + IW'(1);
      end
      if (complete) begin
        out_data    <= frame_bits;
        frame_count <= frame_count + 16'd1;
      end
      if (err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

endmodule

`default_nettype wire
